// File: rtl/phys_reg_free_list_if.sv
// Dispatch/retire/kill bundle between the free list and its neighbours.
// The slave side is the free list itself; the master side is the surrounding pipeline.
interface phys_reg_free_list_if #(
  parameter int PT = 6,
  parameter int CW = 6
);
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          dispatch_free_reg_valid;
  logic [PT-1:0] dispatch_free_reg_tag;
  logic          dispatch_dequeue;
  logic          ROB_retire_valid;
  logic [PT-1:0] ROB_retire_phys_reg_tag;
  logic          kill_bus_valid;
  logic [PT-1:0] kill_bus_speculated_phys_reg_tag;

  modport master (
    input  full, empty, count, dispatch_free_reg_valid, dispatch_free_reg_tag,
    output dispatch_dequeue, ROB_retire_valid, ROB_retire_phys_reg_tag,
           kill_bus_valid, kill_bus_speculated_phys_reg_tag
  );

  modport slave (
    output full, empty, count, dispatch_free_reg_valid, dispatch_free_reg_tag,
    input  dispatch_dequeue, ROB_retire_valid, ROB_retire_phys_reg_tag,
           kill_bus_valid, kill_bus_speculated_phys_reg_tag
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: two enqueues (retire, kill) and
// one dequeue (dispatch) per cycle, with a registered protocol-error pulse.
module phys_reg_free_list #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS
) (
  input  logic                 CLK,
  input  logic                 nRST,
  output logic                 DUT_error,
  phys_reg_free_list_if.slave  fl
);
  localparam int PT = $clog2(NUM_PHYS_REGS);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PT-1:0] mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;
  logic [PW-1:0] count_w;

  logic          deq_ok;
  logic [PW:0]   space;
  logic          retire_ok;
  logic          kill_ok;
  logic [IW-1:0] retire_idx;
  logic [IW-1:0] kill_idx;
  logic [PW-1:0] n_acc;
  logic          err_next;

  assign count_w = tail_ptr - head_ptr;

  assign fl.count                   = CW'(count_w);
  assign fl.empty                   = (count_w == '0);
  assign fl.full                    = (count_w == PW'(DEPTH));
  assign fl.dispatch_free_reg_valid = !fl.empty;
  assign fl.dispatch_free_reg_tag   = mem[head_ptr[IW-1:0]];

  // A same-cycle dequeue frees its slot for this cycle's enqueues.
  assign deq_ok = fl.dispatch_dequeue && !fl.empty;
  assign space  = (PW+1)'(DEPTH) - {1'b0, count_w} + (PW+1)'(deq_ok);

  assign retire_ok = fl.ROB_retire_valid && (space != '0);
  assign kill_ok   = fl.kill_bus_valid &&
                     (space >= (retire_ok ? (PW+1)'(2) : (PW+1)'(1)));

  assign retire_idx = tail_ptr[IW-1:0];
  assign kill_idx   = tail_ptr[IW-1:0] + IW'(retire_ok);
  assign n_acc      = PW'(retire_ok) + PW'(kill_ok);

  assign err_next =
      (fl.dispatch_dequeue && fl.empty) ||
      (fl.ROB_retire_valid && !retire_ok) ||
      (fl.kill_bus_valid && !kill_ok) ||
      (fl.ROB_retire_valid && fl.kill_bus_valid &&
       (fl.ROB_retire_phys_reg_tag == fl.kill_bus_speculated_phys_reg_tag)) ||
      (fl.ROB_retire_valid && (fl.ROB_retire_phys_reg_tag < PT'(NUM_ARCH_REGS))) ||
      (fl.kill_bus_valid && (fl.kill_bus_speculated_phys_reg_tag < PT'(NUM_ARCH_REGS)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_ptr  <= '0;
      tail_ptr  <= PW'(DEPTH);
      DUT_error <= 1'b0;
    end else begin
      head_ptr  <= head_ptr + PW'(deq_ok);
      tail_ptr  <= tail_ptr + n_acc;
      DUT_error <= err_next;
    end
  end

  // Out of reset every non-architectural tag is free, in ascending order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= PT'(NUM_ARCH_REGS + i);
      end
    end else begin
      if (retire_ok) mem[retire_idx] <= fl.ROB_retire_phys_reg_tag;
      if (kill_ok)   mem[kill_idx]   <= fl.kill_bus_speculated_phys_reg_tag;
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: a queue of expected free tags is
// updated as stimulus is driven and compared against the head every cycle.
module tb_phys_reg_free_list;
  logic CLK;
  logic nRST;
  logic DUT_error;

  phys_reg_free_list_if #(.PT(6), .CW(6)) bus ();

  phys_reg_free_list dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .DUT_error (DUT_error),
    .fl        (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int q[$];
  bit exp_err  = 1'b0;
  int next_tag = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("count", int'(bus.count), q.size());
    check("empty", int'(bus.empty), int'(q.size() == 0));
    check("full",  int'(bus.full),  int'(q.size() == 32));
    check("valid", int'(bus.dispatch_free_reg_valid), int'(q.size() != 0));
    if (q.size() != 0) check("head_tag", int'(bus.dispatch_free_reg_tag), q[0]);
    check("error", int'(DUT_error), int'(exp_err));
  endtask

  task automatic drive(input bit deq, input bit rv, input int rt, input bit kv, input int kt);
    bus.dispatch_dequeue                 = deq;
    bus.ROB_retire_valid                 = rv;
    bus.ROB_retire_phys_reg_tag          = rt[5:0];
    bus.kill_bus_valid                   = kv;
    bus.kill_bus_speculated_phys_reg_tag = kt[5:0];
  endtask

  // One cycle: check outputs from registered state, advance the model, drive inputs.
  task automatic step(input bit deq, input bit rv, input int rt, input bit kv, input int kt);
    int space;
    bit dok, rok, kok;
    @(negedge CLK);
    check_outputs();
    dok = deq && (q.size() > 0);
    if (dok) void'(q.pop_front());
    space = 32 - q.size();
    rok = rv && (space >= 1);
    if (rok) begin q.push_back(rt); space--; end
    kok = kv && (space >= 1);
    if (kok) q.push_back(kt);
    exp_err = (deq && !dok) || (rv && !rok) || (kv && !kok) ||
              (rv && kv && (rt == kt)) || (rv && rt < 32) || (kv && kt < 32);
    drive(deq, rv, rt, kv, kt);
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 32; i++) q.push_back(32 + i);
    exp_err = 1'b0;
  endtask

  function automatic int fresh_tag();
    next_tag = (next_tag + 1) % 32;
    return 32 + next_tag;
  endfunction

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    while (q.size() > 0) step(1, 0, 0, 0, 0);
  endtask

  task automatic fill_dual();
    int a;
    while (q.size() < 32) begin
      a = fresh_tag();
      step(0, 1, a, 1, fresh_tag());
    end
  endtask

  initial begin
    nRST = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_outputs();
    @(negedge CLK);
    nRST = 1'b1;

    // Reset and drain: tags 32..63 in order.
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0);
    idle();

    // Dual enqueue ordering from empty.
    step(0, 1, 40, 1, 50);
    idle();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    idle();

    // Underflow, then empty with same-cycle enqueue (no bypass).
    step(1, 0, 0, 0, 0);
    idle();
    idle();
    step(1, 1, 35, 0, 0);
    idle();
    drain();
    idle();

    // Wrap-around with alternating single and dual enqueues.
    for (int rep = 0; rep < 3; rep++) begin
      if (rep == 1) begin
        for (int i = 0; i < 30; i++) step(0, 1, fresh_tag(), 0, 0);
      end else begin
        for (int i = 0; i < 15; i++) step(0, 1, fresh_tag(), 1, fresh_tag());
      end
      for (int i = 0; i < 30; i++) step(1, 0, 0, 0, 0);
    end
    idle();

    // Full with dequeue+retire, then overflow at count 31.
    fill_dual();
    step(1, 1, 45, 0, 0);
    idle();
    drain();
    fill_dual();
    step(1, 0, 0, 0, 0);
    step(0, 1, 33, 1, 34);
    idle();
    drain();
    idle();

    // Random traffic including bad tags and double frees.
    for (int i = 0; i < 300; i++) begin
      int rt, kt;
      rt = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(32, 63);
      kt = ($urandom_range(0, 9) == 0) ? rt : $urandom_range(32, 63);
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), rt,
           bit'($urandom_range(0, 1)), kt);
    end
    idle();

    // Mid-operation asynchronous reset at count 5.
    drain();
    for (int i = 0; i < 5; i++) step(0, 1, fresh_tag(), 0, 0);
    idle();
    step(0, 1, 40, 1, 41);
    #2;
    nRST = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge CLK);
    drive(0, 0, 0, 0, 0);
    check_outputs();
    nRST = 1'b1;
    idle();
    step(1, 0, 0, 0, 0);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
